// File: rtl/citi_mc_iir.sv
// Time-multiplexed multi-channel cascade of direct-form-I biquads on one shared MAC.
// Define CITI_SAT_EN to saturate each section result instead of wrapping it.
module citi_mc_iir #(
   parameter int DW   = 16,
   parameter int CW   = 16,
   parameter int FRAC = 14,
   parameter int NSEC = 4,
   parameter int NCH  = 2,
   parameter int AW   = 40
) (
   input  logic              clk30x,
   input  logic              rst,
   input  logic [31:0]       timing,
   input  logic [NCH*DW-1:0] xin,
   output logic [NCH*DW-1:0] yout,
   output logic              yvalid,
   output logic              busy,
   output logic              overrun,
   input  logic              coef_we,
   input  logic [7:0]        coef_addr,
   input  logic [CW-1:0]     coef_wdata
);

   localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int SECW = (NSEC > 1) ? $clog2(NSEC) : 1;
   localparam int NDW  = $clog2(NSEC + 1);
   localparam int PW   = CW + DW;
   localparam logic [SECW-1:0] LAST_SEC = SECW'(NSEC - 1);
   localparam logic [CHW-1:0]  LAST_CH  = CHW'(NCH - 1);
   localparam logic [CW-1:0]   B0_RST   = {{(CW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};
   localparam logic [AW-1:0]   RND_C    = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Round half up, drop the fractional bits, then fit the result into DW bits.
   function automatic logic [DW-1:0] scale_f(input logic [AW-1:0] acc);
      logic signed [AW-1:0] rnd;
`ifdef CITI_SAT_EN
      logic signed [AW-1:0] shr;
      logic signed [AW-1:0] smax;
      logic signed [AW-1:0] smin;
      rnd  = acc + RND_C;
      shr  = rnd >>> FRAC;
      smax = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
      smin = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
      if (shr > smax) begin
         scale_f = smax[DW-1:0];
      end else if (shr < smin) begin
         scale_f = smin[DW-1:0];
      end else begin
         scale_f = shr[DW-1:0];
      end
`else
      rnd     = acc + RND_C;
      scale_f = DW'(rnd >>> FRAC);
`endif
   endfunction

   state_t            state_q, state_d;
   logic [31:0]       tcnt_q, tcnt_d;
   logic [2:0]        step_q, step_d;
   logic [SECW-1:0]   sec_q, sec_d;
   logic [CHW-1:0]    ch_q, ch_d;
   logic [AW-1:0]     acc_q, acc_d;
   logic              busy_q, busy_d;
   logic              yvalid_q, yvalid_d;
   logic              overrun_q, overrun_d;
   logic [NCH*DW-1:0] yout_q, yout_d;
   logic              pend_vld_q, pend_vld_d;
   logic [7:0]        pend_addr_q, pend_addr_d;
   logic [CW-1:0]     pend_data_q, pend_data_d;

   logic [DW-1:0]     in_q   [NCH];
   logic [DW-1:0]     res_q  [NCH];
   logic [DW-1:0]     sec_in_q;
   logic [DW-1:0]     d1_q   [NCH][NSEC+1];
   logic [DW-1:0]     d2_q   [NCH][NSEC+1];
   logic [CW-1:0]     coef_q [NSEC][5];

   logic              strike_s, capture_s, wb_s, done_s, acc_en_s, last_sec_s;
   logic              coef_wr_s;
   logic [7:0]        coef_wa_s;
   logic [CW-1:0]     coef_wd_s;
   logic [NDW-1:0]    node_s, node_nx_s;
   logic [DW-1:0]     x_s, opd_s, y_s;
   logic [CW-1:0]     cf_s;
   logic [PW-1:0]     prod_s;
   logic [AW-1:0]     prod_ext_s, acc_base_s;

   assign strike_s   = (tcnt_q == 32'd0);
   assign tcnt_d     = (tcnt_q >= timing) ? 32'd0 : tcnt_q + 32'd1;
   assign last_sec_s = (sec_q == LAST_SEC);
   assign node_s     = NDW'(sec_q);
   assign node_nx_s  = node_s + NDW'(1'b1);

   // Sequencer: channel-major, sections in order, six cycles per section.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      sec_d     = sec_q;
      ch_d      = ch_q;
      capture_s = 1'b0;
      wb_s      = 1'b0;
      done_s    = 1'b0;
      acc_en_s  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (strike_s) begin
               capture_s = 1'b1;
               state_d   = ST_RUN;
               step_d    = 3'd0;
               sec_d     = '0;
               ch_d      = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (step_q == 3'd5) begin
               wb_s   = 1'b1;
               step_d = 3'd0;
               if (last_sec_s) begin
                  sec_d = '0;
                  if (ch_q == LAST_CH) begin
                     state_d = ST_DONE;
                  end else begin
                     ch_d = ch_q + CHW'(1'b1);
                  end
               end else begin
                  sec_d = sec_q + SECW'(1'b1);
               end
            end else begin
               acc_en_s = 1'b1;
               step_d   = step_q + 3'd1;
            end
         end
         ST_DONE: begin
            done_s  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // MAC operand selection and accumulate; a1/a2 terms are subtracted.
   always_comb begin
      x_s = (sec_q == '0) ? in_q[ch_q] : sec_in_q;
      case (step_q)
         3'd0: begin opd_s = x_s;                     cf_s = coef_q[sec_q][0]; end
         3'd1: begin opd_s = d1_q[ch_q][node_s];      cf_s = coef_q[sec_q][1]; end
         3'd2: begin opd_s = d2_q[ch_q][node_s];      cf_s = coef_q[sec_q][2]; end
         3'd3: begin opd_s = d1_q[ch_q][node_nx_s];   cf_s = coef_q[sec_q][3]; end
         3'd4: begin opd_s = d2_q[ch_q][node_nx_s];   cf_s = coef_q[sec_q][4]; end
         default: begin opd_s = '0;                   cf_s = '0;               end
      endcase
      prod_s     = {{DW{cf_s[CW-1]}}, cf_s} * {{CW{opd_s[DW-1]}}, opd_s};
      prod_ext_s = {{(AW-PW){prod_s[PW-1]}}, prod_s};
      acc_base_s = (step_q == 3'd0) ? '0 : acc_q;
      if (step_q >= 3'd3) begin
         acc_d = acc_base_s - prod_ext_s;
      end else begin
         acc_d = acc_base_s + prod_ext_s;
      end
      y_s = scale_f(acc_q);
   end

   // Status flags and output word.
   always_comb begin
      busy_d    = capture_s ? 1'b1 : (done_s ? 1'b0 : busy_q);
      yvalid_d  = done_s;
      overrun_d = overrun_q | (strike_s & busy_q);
      yout_d    = yout_q;
      for (int c = 0; c < NCH; c++) begin
         yout_d[c*DW +: DW] = done_s ? res_q[c] : yout_q[c*DW +: DW];
      end
   end

   // Coefficient writes land directly when idle, are parked while busy, and drain on return to idle.
   always_comb begin
      coef_wr_s   = 1'b0;
      coef_wa_s   = coef_addr;
      coef_wd_s   = coef_wdata;
      pend_vld_d  = pend_vld_q;
      pend_addr_d = pend_addr_q;
      pend_data_d = pend_data_q;
      case (state_q)
         ST_IDLE: begin
            coef_wr_s = coef_we;
         end
         ST_DONE: begin
            pend_vld_d = 1'b0;
            if (coef_we) begin
               coef_wr_s = 1'b1;
            end else begin
               coef_wr_s = pend_vld_q;
               coef_wa_s = pend_addr_q;
               coef_wd_s = pend_data_q;
            end
         end
         default: begin
            if (coef_we) begin
               pend_vld_d  = 1'b1;
               pend_addr_d = coef_addr;
               pend_data_d = coef_wdata;
            end else begin
               pend_vld_d = pend_vld_q;
            end
         end
      endcase
   end

   // Control and status registers.
   always_ff @(posedge clk30x or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         tcnt_q      <= 32'd0;
         step_q      <= 3'd0;
         sec_q       <= '0;
         ch_q        <= '0;
         acc_q       <= '0;
         busy_q      <= 1'b0;
         yvalid_q    <= 1'b0;
         overrun_q   <= 1'b0;
         yout_q      <= '0;
         pend_vld_q  <= 1'b0;
         pend_addr_q <= 8'd0;
         pend_data_q <= '0;
      end else begin
         state_q     <= state_d;
         tcnt_q      <= tcnt_d;
         step_q      <= step_d;
         sec_q       <= sec_d;
         ch_q        <= ch_d;
         if (acc_en_s) acc_q <= acc_d;
         busy_q      <= busy_d;
         yvalid_q    <= yvalid_d;
         overrun_q   <= overrun_d;
         yout_q      <= yout_d;
         pend_vld_q  <= pend_vld_d;
         pend_addr_q <= pend_addr_d;
         pend_data_q <= pend_data_d;
      end
   end

   // Input capture, section chaining and delay-line shifts.
   always_ff @(posedge clk30x or posedge rst) begin
      if (rst) begin
         sec_in_q <= '0;
         for (int c = 0; c < NCH; c++) begin
            in_q[c]  <= '0;
            res_q[c] <= '0;
            for (int n = 0; n <= NSEC; n++) begin
               d1_q[c][n] <= '0;
               d2_q[c][n] <= '0;
            end
         end
      end else begin
         if (capture_s) begin
            for (int c = 0; c < NCH; c++) begin
               in_q[c] <= xin[c*DW +: DW];
            end
         end
         if (wb_s) begin
            sec_in_q              <= y_s;
            d2_q[ch_q][node_s]    <= d1_q[ch_q][node_s];
            d1_q[ch_q][node_s]    <= x_s;
            if (last_sec_s) begin
               d2_q[ch_q][NSEC] <= d1_q[ch_q][NSEC];
               d1_q[ch_q][NSEC] <= y_s;
               res_q[ch_q]      <= y_s;
            end
         end
      end
   end

   // Coefficient bank; reset leaves every section as a unity passthrough.
   always_ff @(posedge clk30x or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NSEC; k++) begin
            for (int j = 0; j < 5; j++) begin
               coef_q[k][j] <= (j == 0) ? B0_RST : '0;
            end
         end
      end else if (coef_wr_s) begin
         for (int k = 0; k < NSEC; k++) begin
            for (int j = 0; j < 5; j++) begin
               if (coef_wa_s == 8'(5*k + j)) coef_q[k][j] <= coef_wd_s;
            end
         end
      end
   end

   assign yout    = yout_q;
   assign yvalid  = yvalid_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_citi_mc_iir.sv
// Directed bench for citi_mc_iir: a sample-level reference model checked every cycle,
// plus hand-computed expectations from the filter's defining equations.
module tb_citi_mc_iir;

   localparam int NCH  = 2;
   localparam int NSEC = 4;
   localparam int C    = 6 * NCH * NSEC + 1;

   logic        clk30x = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] timing = 32'd59;
   logic [31:0] xin = 32'd0;
   logic [31:0] yout;
   logic        yvalid, busy, overrun;
   logic        coef_we = 1'b0;
   logic [7:0]  coef_addr = 8'd0;
   logic [15:0] coef_wdata = 16'd0;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   citi_mc_iir dut (
      .clk30x(clk30x), .rst(rst), .timing(timing), .xin(xin),
      .yout(yout), .yvalid(yvalid), .busy(busy), .overrun(overrun),
      .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
   );

   always #5 clk30x = ~clk30x;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- sample-level reference model ----------------
   logic [31:0] tc_m;
   bit          busy_m, yv_m, ov_m, pend_m;
   longint      cyc_m, done_at_m;
   logic [31:0] yout_m;
   int          res_m [NCH];
   int          coef_m [NSEC][5];
   int          pa_m, pd_m;
   int          xh1 [NCH][NSEC], xh2 [NCH][NSEC], yh1 [NCH][NSEC], yh2 [NCH][NSEC];

   function automatic int scale_m(input longint acc);
      longint r;
`ifdef CITI_SAT_EN
      r = (acc + 64'sd8192) >>> 14;
      if (r > 32767) return 32767;
      if (r < -32768) return -32768;
      return int'(r);
`else
      logic [63:0] rb;
      logic [15:0] t;
      r  = (acc + 64'sd8192) >>> 14;
      rb = r;
      t  = rb[15:0];
      return int'($signed(t));
`endif
   endfunction

   task automatic model_reset();
      tc_m = 32'd0; busy_m = 0; yv_m = 0; ov_m = 0; pend_m = 0;
      cyc_m = 0; done_at_m = -1; yout_m = 32'd0; pa_m = 0; pd_m = 0;
      for (int c = 0; c < NCH; c++) begin
         res_m[c] = 0;
         for (int k = 0; k < NSEC; k++) begin
            xh1[c][k] = 0; xh2[c][k] = 0; yh1[c][k] = 0; yh2[c][k] = 0;
         end
      end
      for (int k = 0; k < NSEC; k++)
         for (int j = 0; j < 5; j++) coef_m[k][j] = (j == 0) ? 16384 : 0;
   endtask

   task automatic apply_coef(input int a, input int d);
      logic [15:0] dv;
      dv = d[15:0];
      if (a < 5 * NSEC) coef_m[a / 5][a % 5] = int'($signed(dv));
   endtask

   task automatic run_cascade();
      int v, y;
      logic [15:0] xs;
      longint acc;
      for (int c = 0; c < NCH; c++) begin
         xs = xin[c*16 +: 16];
         v  = int'($signed(xs));
         for (int k = 0; k < NSEC; k++) begin
            acc = longint'(coef_m[k][0]) * v + longint'(coef_m[k][1]) * xh1[c][k]
                + longint'(coef_m[k][2]) * xh2[c][k] - longint'(coef_m[k][3]) * yh1[c][k]
                - longint'(coef_m[k][4]) * yh2[c][k];
            y = scale_m(acc);
            xh2[c][k] = xh1[c][k]; xh1[c][k] = v;
            yh2[c][k] = yh1[c][k]; yh1[c][k] = y;
            v = y;
         end
         res_m[c] = v;
      end
   endtask

   task automatic model_step();
      bit strike, was_busy;
      if (rst) begin
         model_reset();
      end else begin
         strike   = (tc_m == 32'd0);
         tc_m     = (tc_m >= timing) ? 32'd0 : tc_m + 32'd1;
         was_busy = busy_m;
         yv_m     = 0;
         cyc_m++;
         if (coef_we) begin
            if (was_busy) begin pend_m = 1; pa_m = coef_addr; pd_m = coef_wdata; end
            else apply_coef(coef_addr, coef_wdata);
         end
         if (was_busy && cyc_m == done_at_m) begin
            for (int c = 0; c < NCH; c++) yout_m[c*16 +: 16] = res_m[c][15:0];
            yv_m = 1; busy_m = 0;
            if (pend_m) apply_coef(pa_m, pd_m);
            pend_m = 0;
         end
         if (strike) begin
            if (was_busy) ov_m = 1;
            else begin
               run_cascade();
               busy_m = 1;
               done_at_m = cyc_m + C;
            end
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk30x);
         model_step();
      end
   end

   // Every-cycle comparison against the model (reset values while rst is high).
   initial begin
      forever begin
         @(negedge clk30x);
         if (chk_en) begin
            if (rst) begin
               chk("rst_yvalid", {31'd0, yvalid}, 32'd0);
               chk("rst_busy", {31'd0, busy}, 32'd0);
               chk("rst_overrun", {31'd0, overrun}, 32'd0);
               chk("rst_yout", yout, 32'd0);
            end else begin
               chk("yvalid", {31'd0, yvalid}, {31'd0, yv_m});
               chk("busy", {31'd0, busy}, {31'd0, busy_m});
               chk("overrun", {31'd0, overrun}, {31'd0, ov_m});
               chk("yout", yout, yout_m);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk30x);
      #1;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (n < 300) begin
         @(negedge clk30x);
         n++;
         if (yvalid) break;
      end
      chk("yvalid_seen", {31'd0, yvalid}, 32'd1);
   endtask

   task automatic do_reset(input logic [31:0] t, input logic [31:0] x);
      rst = 1'b1; timing = t; xin = x;
      tick(); tick();
      chk_en = 1'b1;
      rst = 1'b0;
   endtask

   initial begin
      int n, p;
      // Passthrough after reset, latency of C cycles
      rst = 1'b1; timing = 32'd59; xin = 32'hF000_1234;
      tick(); tick();
      chk_en = 1'b1;
      @(negedge clk30x);
      chk("reset_yout", yout, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      tick();
      rst = 1'b0;
      @(posedge clk30x);
      wait_valid(n);
      chk("pass_latency", n - 1, 32'd49);
      chk("pass_ch0", {16'd0, yout[15:0]}, 32'h1234);
      chk("pass_ch1", {16'd0, yout[31:16]}, 32'hF000);
      chk("pass_busy", {31'd0, busy}, 32'd0);

      // First-order impulse: y = x/2 + y1/2
      do_reset(32'd59, 32'd0);
      wait_valid(n);
      chk("imp_zero", yout, 32'd0);
      tick(); coef_we = 1'b1; coef_addr = 8'd0; coef_wdata = 16'h2000;
      tick(); coef_addr = 8'd3; coef_wdata = 16'hE000;
      tick(); coef_we = 1'b0; xin = 32'h0000_4000;
      wait_valid(n);
      chk("imp0", {16'd0, yout[15:0]}, 32'h2000);
      tick(); xin = 32'd0;
      wait_valid(n);
      chk("imp1", {16'd0, yout[15:0]}, 32'h1000);
      wait_valid(n);
      chk("imp2", {16'd0, yout[15:0]}, 32'h0800);
      wait_valid(n);
      chk("imp3", {16'd0, yout[15:0]}, 32'h0400);

      // Overflow: write lands on the very first strike edge
      rst = 1'b1; coef_we = 1'b1; coef_addr = 8'd0; coef_wdata = 16'h7FFF;
      do_reset(32'd59, 32'h0000_7FFF);
      tick(); coef_we = 1'b0;
      wait_valid(n);
`ifdef CITI_SAT_EN
      chk("ovf_sat", {16'd0, yout[15:0]}, 32'h7FFF);
`else
      chk("ovf_wrap", {16'd0, yout[15:0]}, 32'hFFFC);
`endif

      // Coefficient write during RUN is deferred
      do_reset(32'd59, 32'h0222_1111);
      repeat (10) tick();
      coef_we = 1'b1; coef_addr = 8'd0; coef_wdata = 16'h2000;
      tick(); coef_we = 1'b0;
      wait_valid(n);
      chk("bw_cur", {16'd0, yout[15:0]}, 32'h1111);
      tick(); xin = 32'h0000_4000;
      wait_valid(n);
      chk("bw_next", {16'd0, yout[15:0]}, 32'h2000);

      // Reset in the middle of a computation
      n = 0;
      while (n < 100) begin
         @(negedge clk30x);
         n++;
         if (busy) break;
      end
      chk("rm_busy_seen", {31'd0, busy}, 32'd1);
      repeat (20) tick();
      rst = 1'b1; xin = 32'h0000_0ABC;
      @(negedge clk30x);
      chk("rm_yout", yout, 32'd0);
      chk("rm_busy", {31'd0, busy}, 32'd0);
      tick(); tick();
      rst = 1'b0;
      wait_valid(n);
      chk("rm_pass", {16'd0, yout[15:0]}, 32'h0ABC);

      // Overrun with a short period
      do_reset(32'd20, 32'h0001_0001);
      p = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk30x);
         if (yvalid) p++;
         if (i == 21) chk("ov_before", {31'd0, overrun}, 32'd0);
         if (i == 22) chk("ov_after", {31'd0, overrun}, 32'd1);
      end
      chk("ov_pulses", p, 32'd3);
      chk("ov_sticky", {31'd0, overrun}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
